cart_bank_mapper: RTL and testbench
===================================

// Module: cart_bank_mapper
// PURPOSE
// Cartridge ROM subsystem for the CoCo/Dragon core, replacing the fixed 16K romC store and ad-hoc cart_loaded latch.
// Receives a cartridge image over the ioctl download bus into 2^BANK_BITS x 16K banks and maps one bank into $C000-$FEFF.
// A bank register is written at BANK_REG_ADDR. The block generates the CART autostart square wave for PIA1 CB1.
// PARAMETERS
// BANK_BITS      2        log2 of the 16K bank count; image capacity is 2^BANK_BITS*16K.
// CART_INDEX     1        ioctl_index value that selects a cartridge download.
// MIN_CART_SIZE  'h100    an image must be strictly larger than this many bytes to count as loaded.
// BANK_REG_ADDR  'hFF40   CPU address of the write-only bank register.
// AUTOSTART_HALF 4        half-period of the CART square wave, in clk_ena ticks (>=1).
// PORTS
// clk           in   1              system clock, 57.272 MHz
// reset         in   1              synchronous, active-low
// clk_ena       in   1              CPU-rate enable (turbo: tied 1)
// cpu_addr      in   16             CPU address
// cpu_dout      in   8              CPU write data
// cpu_we        in   1              CPU write strobe (~rw & E)
// romC_cs       in   1              cartridge ROM select from the 74LS138 decode
// romC_dout     out  8              cartridge read data
// ioctl_download in  1              download active
// ioctl_index   in   8              download target
// ioctl_wr      in   1              one-clk byte write strobe
// ioctl_addr    in   BANK_BITS+14   byte address within the image
// ioctl_data    in   8              byte data
// autostart_en  in   1              OSD enable for the CART signal
// cart          out  1              CART line to PIA1 cb1_in
// cart_loaded   out  1              a valid image is present
// bank          out  BANK_BITS      current bank, for debug overlay
// BEHAVIOUR
// Reset (reset==0) forces: state=IDLE, cart_loaded=0, bank=0, mask=0, cart=0, romC_dout=8'hFF, divider=0.
// Memory contents are not cleared by reset.
// FSM states: IDLE, LOADING, DONE.
//  - Any state -> LOADING on a rising edge of (ioctl_download & ioctl_index==CART_INDEX).
//    On entry: byte_count=0, cart_loaded=0, bank=0, mask=0.
//  - LOADING -> DONE on the falling edge of that term.
//    On this transition: cart_loaded <= (byte_count > MIN_CART_SIZE); mask <= smear(hi), where
//    hi = (byte_count-1)>>14 and smear(x) = x|x>>1|...; if byte_count==0 then mask=0.
//  - Downloads with a non-matching index are ignored in every state.
// Write path, LOADING only: on ioctl_wr, write mem[ioctl_addr] <= ioctl_data and
//   byte_count <= max(byte_count, ioctl_addr+1). byte_count is BANK_BITS+15 bits wide, so it never wraps.
//  - An ioctl_wr in the same clk as the download falling edge is written and counted before mask/cart_loaded are computed.
//  - ioctl_wr outside LOADING is dropped.
// Bank register: on clk_ena & cpu_we & cpu_addr==BANK_REG_ADDR, bank <= cpu_dout[BANK_BITS-1:0] & mask.
//  - Indices beyond the loaded image wrap modulo the power-of-two-rounded size.
//  - Writes are ignored while in LOADING.
// Read path: mem address = {bank, cpu_addr[13:0]}.
//  - romC_dout is registered, 1 clk latency, and updates every clk regardless of clk_ena.
//  - romC_dout = 8'hFF when in LOADING or when romC_cs==0.
//  - A bank write and a read in the same clk: the read uses the old bank.
// Autostart: when cart_loaded & autostart_en & state==DONE, a divider counts clk_ena ticks and toggles cart every AUTOSTART_HALF ticks.
//  - Otherwise divider=0 and cart=0, taking effect on the next clk.
// Reset mid-download: state returns to IDLE.
//  - Remaining ioctl_wr pulses are dropped until a fresh rising edge of the download term.
// STRUCTURE
// Include file coco_cart_defs.vh: FSM state localparams, default BANK_REG_ADDR, CART_INDEX.
// One sub-module: the existing dpram (addr_width_g=BANK_BITS+14, data_width_g=8).
//  - Port a: CPU reads. Port b: ioctl writes.
// The FSM, byte counter, mask smear, bank register and autostart divider stay in this module.
// TESTING
// T1: hold reset low for 3 clk -> cart_loaded=0, bank=0, cart=0, romC_dout=FF; ioctl_wr pulses with download low leave memory unchanged.
// T2: download 'h100 bytes -> cart_loaded=0; re-download 'h101 bytes -> cart_loaded=1, cart toggles every 4 clk_ena ticks.
// T3: BANK_BITS=2, download 40K with byte n = n[7:0]^n[15:8]; write 05 to FF40 -> bank=1 (mask=3);
//     read $C010 -> romC_dout = byte at 'h4010 one clk later.
// T4: download 16K -> mask=0; write 03 to FF40 -> bank=0; read $C000 returns image byte 0.
// T5: ioctl_wr at addr 'h7FFF in the same clk as the download falling edge -> byte_count='h8000, mask=1, cart_loaded=1.
// T6: reset low after 'h200 bytes mid-download, then release with download still high -> state IDLE, cart_loaded=0,
//     further ioctl_wr dropped; new download edge restarts the load correctly.

Source files
------------

// File: rtl/cart_bank_mapper_pkg.sv
// Shared types and defaults for the cartridge bank mapper.
// Holds the load FSM encoding and the default CPU/ioctl decode values.
package cart_bank_mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [7:0]  CART_INDEX_DEF    = 8'd1;
  localparam logic [15:0] BANK_REG_ADDR_DEF = 16'hFF40;
  localparam int          BANK_SHIFT        = 14;
  localparam logic [7:0]  ROM_IDLE_BYTE     = 8'hFF;

endpackage

// File: rtl/cart_bank_mapper_dpram.sv
// Simple dual-port RAM: port a is a registered read, port b a write.
// Same shape as the project's existing dpram so it maps onto block RAM.
module cart_bank_mapper_dpram #(
  parameter int addr_width_g = 16,
  parameter int data_width_g = 8
) (
  input  logic                    clk,
  input  logic [addr_width_g-1:0] address_a,
  output logic [data_width_g-1:0] q_a,
  input  logic [addr_width_g-1:0] address_b,
  input  logic                    wren_b,
  input  logic [data_width_g-1:0] data_b
);

  logic [data_width_g-1:0] mem [2**addr_width_g];

  // NOTE: the array has no reset: a RAM cannot be cleared in one clock, and a
  // reset branch here would stop the tools from mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (wren_b) begin
      mem[address_b] <= data_b;
    end
    q_a <= mem[address_a];
  end

endmodule

// File: rtl/cart_bank_mapper.sv
// Cartridge ROM loader and bank mapper: captures an ioctl image into banked RAM,
// maps one 16K bank at $C000 and drives the CART autostart square wave.
module cart_bank_mapper
  import cart_bank_mapper_pkg::*;
#(
  parameter int          BANK_BITS      = 2,
  parameter logic [7:0]  CART_INDEX     = CART_INDEX_DEF,
  parameter int          MIN_CART_SIZE  = 'h100,
  parameter logic [15:0] BANK_REG_ADDR  = BANK_REG_ADDR_DEF,
  parameter int          AUTOSTART_HALF = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_ena,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_dout,
  input  logic                    cpu_we,
  input  logic                    romC_cs,
  output logic [7:0]              romC_dout,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [BANK_BITS+13:0]   ioctl_addr,
  input  logic [7:0]              ioctl_data,
  input  logic                    autostart_en,
  output logic                    cart,
  output logic                    cart_loaded,
  output logic [BANK_BITS-1:0]    bank
);

  localparam int AW = BANK_BITS + BANK_SHIFT;
  localparam int CW = AW + 1;
  localparam int DW = $clog2(AUTOSTART_HALF) + 1;

  state_e               state_q, state_d;
  logic                 dl_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 loaded_q, loaded_d;
  logic [BANK_BITS-1:0] mask_q, mask_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 cart_q, cart_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 rd_idle_q, rd_idle_d;
  logic [7:0]           ram_q;

  logic                 dl_term, dl_rise, dl_fall;
  logic                 wr_en, bank_wr, cart_active;
  logic [CW-1:0]        wr_end;
  logic [BANK_BITS-1:0] hi;

  function automatic logic [BANK_BITS-1:0] smear(input logic [BANK_BITS-1:0] x);
    logic [BANK_BITS-1:0] r;
    r = x;
    for (int i = 1; i < BANK_BITS; i++) begin
      r = r | (x >> i);
    end
    return r;
  endfunction

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; only always_ff uses '<='.
  always_comb begin
    dl_term     = ioctl_download && (ioctl_index == CART_INDEX);
    dl_rise     = dl_term && !dl_q;
    dl_fall     = !dl_term && dl_q;
    wr_en       = (state_q == ST_LOADING) && ioctl_wr;
    wr_end      = {1'b0, ioctl_addr} + CW'(1);
    bank_wr     = clk_ena && cpu_we && (cpu_addr == BANK_REG_ADDR);
    cart_active = loaded_q && autostart_en && (state_q == ST_DONE);
    rd_idle_d   = (state_q == ST_LOADING) || !romC_cs;

    state_d  = state_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    mask_d   = mask_q;
    bank_d   = bank_q;
    hi       = '0;

    // A write landing with the download's falling edge is counted first.
    if (wr_en && (wr_end > count_q)) begin
      count_d = wr_end;
    end

    if (dl_rise) begin
      state_d  = ST_LOADING;
      count_d  = '0;
      loaded_d = 1'b0;
      mask_d   = '0;
      bank_d   = '0;
    end else if (state_q == ST_LOADING) begin
      if (dl_fall) begin
        state_d  = ST_DONE;
        loaded_d = count_d > CW'(MIN_CART_SIZE);
        hi       = BANK_BITS'((count_d - CW'(1)) >> BANK_SHIFT);
        mask_d   = (count_d == '0) ? '0 : smear(hi);
      end
    end else if (bank_wr) begin
      bank_d = BANK_BITS'(cpu_dout) & mask_q;
    end

    div_d  = '0;
    cart_d = 1'b0;
    if (cart_active) begin
      div_d  = div_q;
      cart_d = cart_q;
      if (clk_ena) begin
        if (div_q == DW'(AUTOSTART_HALF - 1)) begin
          div_d  = '0;
          cart_d = !cart_q;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      loaded_q  <= 1'b0;
      mask_q    <= '0;
      bank_q    <= '0;
      cart_q    <= 1'b0;
      div_q     <= '0;
      rd_idle_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      loaded_q  <= loaded_d;
      mask_q    <= mask_d;
      bank_q    <= bank_d;
      cart_q    <= cart_d;
      div_q     <= div_d;
      rd_idle_q <= rd_idle_d;
    end
  end

  // Tracks the download term even in reset, so a download still active when
  // reset releases needs a fresh rising edge before loading resumes.
  always_ff @(posedge clk) begin
    dl_q <= dl_term;
  end

  cart_bank_mapper_dpram #(
    .addr_width_g(AW),
    .data_width_g(8)
  ) u_rom (
    .clk      (clk),
    .address_a({bank_q, cpu_addr[BANK_SHIFT-1:0]}),
    .q_a      (ram_q),
    .address_b(ioctl_addr),
    .wren_b   (wr_en),
    .data_b   (ioctl_data)
  );

  assign romC_dout   = rd_idle_q ? ROM_IDLE_BYTE : ram_q;
  assign cart        = cart_q;
  assign cart_loaded = loaded_q;
  assign bank        = bank_q;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed-plus-random bench for cart_bank_mapper with a byte-level image model.
module tb_cart_bank_mapper;

  localparam int         BB   = 2;
  localparam int         AW   = BB + 14;
  localparam int         HALF = 4;
  localparam logic [7:0] IDX  = 8'd1;

  logic          clk = 1'b0;
  logic          reset, clk_ena, cpu_we, romC_cs;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_dout, romC_dout;
  logic          ioctl_download, ioctl_wr, autostart_en;
  logic [7:0]    ioctl_index, ioctl_data;
  logic [AW-1:0] ioctl_addr;
  logic          cart, cart_loaded;
  logic [BB-1:0] bank;

  int tests = 0;
  int fails = 0;

  // Reference model: image bytes, load bookkeeping, autostart tick count.
  logic [7:0] m_mem [int];
  int m_count, m_mask, m_bank, m_ticks;
  bit m_loaded, m_done, m_loading;

  int         fa, b, off;
  logic [7:0] d, exp_b;

  always #5 clk = ~clk;

  cart_bank_mapper #(
    .BANK_BITS(BB), .CART_INDEX(IDX), .MIN_CART_SIZE('h100),
    .BANK_REG_ADDR(16'hFF40), .AUTOSTART_HALF(HALF)
  ) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_we(cpu_we), .romC_cs(romC_cs), .romC_dout(romC_dout),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .autostart_en(autostart_en),
    .cart(cart), .cart_loaded(cart_loaded), .bank(bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Number of banks rounded up to a power of two, minus one.
  function automatic int mask_for(int n);
    int banks = (n + 16383) / 16384;
    int p = 1;
    while (p < banks) p *= 2;
    return p - 1;
  endfunction

  function automatic int exp_cart();
    return (m_ticks / HALF) % 2;
  endfunction

  task automatic step();
    bit act  = reset && m_done && m_loaded && autostart_en;
    bit tick = clk_ena;
    @(posedge clk);
    #1;
    if (act) begin
      if (tick) m_ticks++;
    end else begin
      m_ticks = 0;
    end
  endtask

  task automatic m_write(int a, logic [7:0] v);
    if (m_loading) begin
      m_mem[a] = v;
      if (a + 1 > m_count) m_count = a + 1;
    end
  endtask

  task automatic dl_start();
    ioctl_download = 1'b1;
    ioctl_index    = IDX;
    ioctl_wr       = 1'b0;
    step();
    m_loading = 1; m_done = 0; m_count = 0;
    m_loaded = 0; m_mask = 0; m_bank = 0;
  endtask

  task automatic dl_byte(int a, logic [7:0] v);
    ioctl_wr   = 1'b1;
    ioctl_addr = a[AW-1:0];
    ioctl_data = v;
    step();
    ioctl_wr = 1'b0;
    m_write(a, v);
  endtask

  task automatic dl_end(bit with_wr, int a, logic [7:0] v);
    ioctl_download = 1'b0;
    ioctl_wr       = with_wr;
    ioctl_addr     = a[AW-1:0];
    ioctl_data     = v;
    step();
    ioctl_wr = 1'b0;
    if (with_wr) m_write(a, v);
    if (m_loading) begin
      m_loading = 0;
      m_done    = 1;
      m_loaded  = m_count > 'h100;
      m_mask    = mask_for(m_count);
    end
  endtask

  task automatic bank_write(logic [7:0] v);
    cpu_we   = 1'b1;
    cpu_addr = 16'hFF40;
    cpu_dout = v;
    clk_ena  = 1'b1;
    step();
    cpu_we = 1'b0;
    if (!m_loading) m_bank = int'(v) % (m_mask + 1);
  endtask

  task automatic read_chk(string tag, logic [15:0] a);
    int          full = m_bank * 16384 + int'(a & 16'h3FFF);
    logic [7:0]  e    = m_loading ? 8'hFF : m_mem[full];
    cpu_addr = a;
    romC_cs  = 1'b1;
    step();
    check(tag, romC_dout, e);
    romC_cs = 1'b0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    repeat (n) step();
    reset = 1'b1;
    m_loaded = 0; m_mask = 0; m_bank = 0;
    m_done = 0; m_loading = 0; m_ticks = 0;
  endtask

  initial begin
    reset = 1'b0; clk_ena = 1'b1; cpu_we = 1'b0; romC_cs = 1'b0;
    cpu_addr = 16'h0; cpu_dout = 8'h0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'h0; ioctl_addr = '0; ioctl_data = 8'h0; autostart_en = 1'b0;

    // T1: reset state
    repeat (3) step();
    check("t1_loaded", cart_loaded, 0);
    check("t1_bank", bank, 0);
    check("t1_cart", cart, 0);
    check("t1_romc", romC_dout, 8'hFF);
    reset = 1'b1;
    m_loaded = 0; m_mask = 0; m_bank = 0; m_done = 0; m_loading = 0; m_ticks = 0;

    // T2: exactly MIN bytes is not enough
    dl_start();
    for (int a = 0; a < 'h100; a++) dl_byte(a, 8'($urandom));
    read_chk("t2_read_loading", 16'hC010);
    bank_write(8'h01);
    check("t2_bank_ignored_loading", bank, m_bank);
    dl_end(0, 0, 8'h0);
    check("t2_small_loaded", cart_loaded, m_loaded);
    autostart_en = 1'b1;
    repeat (6) step();
    check("t2_cart_unloaded", cart, 0);

    dl_start();
    for (int a = 0; a <= 'h100; a++) dl_byte(a, 8'($urandom));
    dl_end(0, 0, 8'h0);
    check("t2_loaded", cart_loaded, 1);
    for (int i = 0; i < 40; i++) begin
      clk_ena = 1'($urandom_range(0, 1));
      step();
      check("t2_cart_wave", cart, exp_cart());
    end
    autostart_en = 1'b0;
    clk_ena = 1'b1;
    step();
    check("t2_cart_off", cart, 0);

    // Writes with download low, or with a foreign index, must not land.
    ioctl_download = 1'b0;
    for (int a = 'h10; a < 'h14; a++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(a); ioctl_data = ~m_mem[a];
      step();
    end
    ioctl_wr = 1'b0;
    read_chk("t1_drop_dl_low", 16'hC012);
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    step();
    for (int a = 0; a < 4; a++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(a); ioctl_data = ~m_mem[a];
      step();
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    step();
    check("t2_foreign_idx_loaded", cart_loaded, 1);
    read_chk("t2_foreign_idx_data", 16'hC001);
    romC_cs = 1'b0; cpu_addr = 16'hC001;
    step();
    check("t2_cs_low", romC_dout, 8'hFF);

    // T3: 40K image, three banks rounding to a mask of 3
    dl_start();
    for (int n = 0; n < 40960; n++) dl_byte(n, n[7:0] ^ n[15:8]);
    dl_end(0, 0, 8'h0);
    check("t3_loaded", cart_loaded, 1);
    bank_write(8'h05);
    check("t3_bank5", bank, 1);
    read_chk("t3_read_c010", 16'hC010);
    check("t3_byte4010", romC_dout, 8'h50);

    // Bank write and read in the same clk: the read sees the old bank.
    exp_b = m_mem[m_bank * 16384 + 'h3F40];
    cpu_we = 1'b1; cpu_addr = 16'hFF40; cpu_dout = 8'h02; romC_cs = 1'b1; clk_ena = 1'b1;
    step();
    cpu_we = 1'b0; romC_cs = 1'b0;
    check("t3_read_old_bank", romC_dout, exp_b);
    m_bank = 2;
    check("t3_bank_after", bank, 2);

    for (int i = 0; i < 8; i++) begin
      b   = int'($urandom_range(0, 2));
      off = int'($urandom_range(0, (b == 2) ? 'h1FFF : 'h3EFF));
      bank_write(8'(b + 4 * int'($urandom_range(0, 63))));
      check("t3_rand_bank", bank, m_bank);
      read_chk("t3_rand_read", 16'hC000 | 16'(off));
    end

    // T4: 16K image leaves mask at 0
    dl_start();
    for (int a = 0; a < 16384; a++) dl_byte(a, 8'($urandom));
    dl_end(0, 0, 8'h0);
    bank_write(8'h03);
    check("t4_bank", bank, 0);
    read_chk("t4_read_c000", 16'hC000);

    // T5: single write at 'h7FFF coinciding with the download falling edge
    dl_start();
    d = 8'($urandom);
    dl_end(1, 'h7FFF, d);
    check("t5_loaded", cart_loaded, 1);
    bank_write(8'h03);
    check("t5_bank_mask1", bank, 1);
    read_chk("t5_read_7fff", 16'hFFFF);
    check("t5_byte", romC_dout, d);
    bank_write(8'h02);
    check("t5_bank_wrap", bank, 0);

    // T6: reset in the middle of a download
    dl_start();
    for (int a = 0; a < 'h200; a++) dl_byte(a, 8'($urandom));
    do_reset(2);
    check("t6_loaded_after_rst", cart_loaded, 0);
    check("t6_bank_after_rst", bank, 0);
    read_chk("t6_idle_read", 16'hC000);
    for (int a = 0; a < 4; a++) dl_byte(a, ~m_mem[a]);
    read_chk("t6_dropped_wr", 16'hC002);
    dl_end(0, 0, 8'h0);
    check("t6_loaded_no_edge", cart_loaded, 0);
    dl_start();
    for (int a = 0; a < 'h300; a++) dl_byte(a, 8'($urandom));
    dl_end(0, 0, 8'h0);
    check("t6_reload_loaded", cart_loaded, 1);
    for (int i = 0; i < 4; i++) begin
      read_chk("t6_reload_read", 16'hC000 | 16'($urandom_range(0, 'h2FF)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
